// File: rtl/m_dm_access_pkg.sv
// Shared encodings for the M-stage data-memory agent: load-extend codes, FSM states,
// access sizes and the small helpers that derive access size from the instruction fields.
package m_dm_access_pkg;

    localparam logic [2:0] EXT_WORD  = 3'b000;
    localparam logic [2:0] EXT_UBYTE = 3'b001;
    localparam logic [2:0] EXT_SBYTE = 3'b010;
    localparam logic [2:0] EXT_UHALF = 3'b011;
    localparam logic [2:0] EXT_SHALF = 3'b100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Reserved extend codes fall through to word.
    function automatic logic [1:0] ld_size(input logic [2:0] ext_op);
        case (ext_op)
            EXT_UBYTE, EXT_SBYTE: return SZ_BYTE;
            EXT_UHALF, EXT_SHALF: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic [1:0] st_size(input logic [3:0] be);
        logic [2:0] cnt;
        cnt = {2'b00, be[0]} + {2'b00, be[1]} + {2'b00, be[2]} + {2'b00, be[3]};
        case (cnt)
            3'd4:    return SZ_WORD;
            3'd2:    return SZ_HALF;
            default: return SZ_BYTE;
        endcase
    endfunction

endpackage

// File: rtl/m_dm_access_load_ext.sv
// Combinational lane select and zero/sign extension of a raw data-memory read word.
module m_load_ext
    import m_dm_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ext_op,
    output logic [31:0] ext_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = 8'h00;
        case (addr_lo)
            2'd0:    sel_byte = rdata[7:0];
            2'd1:    sel_byte = rdata[15:8];
            2'd2:    sel_byte = rdata[23:16];
            default: sel_byte = rdata[31:24];
        endcase
        sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext_data = rdata;
        case (ext_op)
            EXT_UBYTE: ext_data = {24'h000000, sel_byte};
            EXT_SBYTE: ext_data = {{24{sel_byte[7]}}, sel_byte};
            EXT_UHALF: ext_data = {16'h0000, sel_half};
            EXT_SHALF: ext_data = {{16{sel_half[15]}}, sel_half};
            default:   ext_data = rdata;
        endcase
    end

endmodule

// File: rtl/m_dm_access.sv
// M-stage data-memory bus agent: req/gnt/rvalid handshake, pipeline stall, load extension,
// misalignment flags and a timeout abort.
module m_dm_access
    import m_dm_access_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m_valid,
    input  logic        m_is_load,
    input  logic        m_dm_we,
    input  logic [2:0]  m_ext_op,
    input  logic [3:0]  m_byteen,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wdata,
    output logic        m_stall,
    output logic [31:0] m_rdata,
    output logic        m_adel,
    output logic        m_ades,
    output logic        m_bus_err,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic [1:0]  dbg_state
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    // Handshake: dm_req rises with addr/be/wdata/we and all of them hold until a cycle with
    // dm_gnt=1; dm_rvalid is honoured only in RESP, or in REQ together with dm_gnt.
    logic [1:0]  state;
    logic [7:0]  tmo_cnt;
    logic [1:0]  addr_lo_q;
    logic [2:0]  ext_op_q;
    logic [1:0]  ld_sz;
    logic [1:0]  st_sz;
    logic        ld_misalign;
    logic        st_misalign;
    logic        access;
    logic        tmo_expire;
    logic [31:0] st_wdata;
    logic [31:0] ext_data;

    always_comb begin
        ld_sz       = ld_size(m_ext_op);
        st_sz       = st_size(m_byteen);
        ld_misalign = 1'b0;
        st_misalign = 1'b0;
        if (ld_sz == SZ_WORD)      ld_misalign = |m_addr[1:0];
        else if (ld_sz == SZ_HALF) ld_misalign = m_addr[0];
        if (st_sz == SZ_WORD)      st_misalign = |m_addr[1:0];
        else if (st_sz == SZ_HALF) st_misalign = m_addr[0];
        st_wdata = {4{m_wdata[7:0]}};
        if (st_sz == SZ_WORD)      st_wdata = m_wdata;
        else if (st_sz == SZ_HALF) st_wdata = {2{m_wdata[15:0]}};
    end

    assign m_adel     = m_valid & m_is_load & ld_misalign;
    assign m_ades     = m_valid & m_dm_we & st_misalign;
    assign access     = m_valid & (m_is_load | m_dm_we) & ~m_adel & ~m_ades;
    assign tmo_expire = (tmo_cnt == TMO_LAST);
    assign m_stall    = ((state == ST_IDLE) & access) | (state == ST_REQ) | (state == ST_RESP);
    assign dbg_state  = state;

    m_load_ext u_load_ext (
        .rdata    (dm_rdata),
        .addr_lo  (addr_lo_q),
        .ext_op   (ext_op_q),
        .ext_data (ext_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            tmo_cnt   <= 8'd0;
            addr_lo_q <= 2'b00;
            ext_op_q  <= EXT_WORD;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= 32'h0;
            dm_be     <= 4'h0;
            dm_wdata  <= 32'h0;
            m_rdata   <= 32'h0;
            m_bus_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access) begin
                        state     <= ST_REQ;
                        tmo_cnt   <= 8'd0;
                        dm_req    <= 1'b1;
                        dm_we     <= m_dm_we;
                        dm_addr   <= {m_addr[31:2], 2'b00};
                        dm_be     <= m_dm_we ? m_byteen : 4'hF;
                        dm_wdata  <= st_wdata;
                        addr_lo_q <= m_addr[1:0];
                        ext_op_q  <= m_ext_op;
                    end
                end
                ST_REQ: begin
                    // A grant in the expiry cycle wins over the timeout.
                    if (dm_gnt) begin
                        dm_req  <= 1'b0;
                        dm_we   <= 1'b0;
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (dm_rvalid) begin
                            m_rdata <= ext_data;
                            state   <= ST_DONE;
                        end else begin
                            state <= ST_RESP;
                        end
                    end else if (tmo_expire) begin
                        dm_req    <= 1'b0;
                        dm_we     <= 1'b0;
                        m_rdata   <= 32'h0;
                        m_bus_err <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    if (dm_rvalid) begin
                        m_rdata <= ext_data;
                        state   <= ST_DONE;
                    end else if (tmo_expire) begin
                        m_rdata   <= 32'h0;
                        m_bus_err <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    m_bus_err <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_dm_access.sv
// Directed bench for m_dm_access: a default instance plus a TIMEOUT_CYC=4 instance on shared inputs.
module tb_m_dm_access;

    logic        clk;
    logic        reset;
    logic        m_valid;
    logic        m_is_load;
    logic        m_dm_we;
    logic [2:0]  m_ext_op;
    logic [3:0]  m_byteen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    logic        m_stall, m_adel, m_ades, m_bus_err, dm_req, dm_we;
    logic [31:0] m_rdata, dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic [1:0]  dbg_state;

    logic        t4_m_stall, t4_m_adel, t4_m_ades, t4_m_bus_err, t4_dm_req, t4_dm_we;
    logic [31:0] t4_m_rdata, t4_dm_addr, t4_dm_wdata;
    logic [3:0]  t4_dm_be;
    logic [1:0]  t4_dbg_state;

    int tests_run = 0;
    int fails = 0;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    m_dm_access u_dut (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_is_load(m_is_load), .m_dm_we(m_dm_we),
        .m_ext_op(m_ext_op), .m_byteen(m_byteen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_stall(m_stall), .m_rdata(m_rdata), .m_adel(m_adel), .m_ades(m_ades),
        .m_bus_err(m_bus_err), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .dbg_state(dbg_state)
    );

    m_dm_access #(.TIMEOUT_CYC(4)) u_dut_t4 (
        .clk(clk), .reset(reset), .m_valid(m_valid), .m_is_load(m_is_load), .m_dm_we(m_dm_we),
        .m_ext_op(m_ext_op), .m_byteen(m_byteen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_stall(t4_m_stall), .m_rdata(t4_m_rdata), .m_adel(t4_m_adel), .m_ades(t4_m_ades),
        .m_bus_err(t4_m_bus_err), .dm_req(t4_dm_req), .dm_we(t4_dm_we), .dm_addr(t4_dm_addr),
        .dm_be(t4_dm_be), .dm_wdata(t4_dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
        .dm_rdata(dm_rdata), .dbg_state(t4_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        reset = 1'b0;
        m_valid = 1'b0; m_is_load = 1'b0; m_dm_we = 1'b0; m_ext_op = 3'b000;
        m_byteen = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic begin_op(input logic ld, input logic we, input logic [2:0] ext,
                            input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        m_valid = 1'b1; m_is_load = ld; m_dm_we = we; m_ext_op = ext;
        m_byteen = be; m_addr = addr; m_wdata = wd;
    endtask

    task automatic end_op();
        m_valid = 1'b0; m_is_load = 1'b0; m_dm_we = 1'b0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Bus responder: grant after gnt_dly REQ cycles, rvalid rv_dly cycles after the grant
    // (0 = same cycle). Returns stall cycles and a snapshot of the first REQ cycle.
    task automatic do_access(input int gnt_dly, input int rv_dly, input logic [31:0] rd,
                             output int stall_cycles, output logic finished,
                             output logic [31:0] s_addr, output logic [3:0] s_be,
                             output logic [31:0] s_wdata, output logic s_we);
        int req_n = 0;
        int after = -1;
        stall_cycles = 0; finished = 1'b0;
        s_addr = 32'hx; s_be = 4'hx; s_wdata = 32'hx; s_we = 1'bx;
        for (int c = 0; c < 400; c++) begin
            #1;
            dm_gnt = 1'b0; dm_rvalid = 1'b0;
            if (!m_stall) begin
                finished = 1'b1;
                break;
            end
            stall_cycles++;
            if (dm_req) begin
                if (req_n == 0) begin
                    s_addr = dm_addr; s_be = dm_be; s_wdata = dm_wdata; s_we = dm_we;
                end
                if (req_n == gnt_dly) begin
                    dm_gnt = 1'b1; after = 0;
                    if (rv_dly == 0) begin dm_rvalid = 1'b1; dm_rdata = rd; end
                end
                req_n++;
            end else if (after >= 0) begin
                after++;
                if (after == rv_dly) begin dm_rvalid = 1'b1; dm_rdata = rd; end
            end
            @(posedge clk); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        m_valid = 1'b0; m_is_load = 1'b0; m_dm_we = 1'b0; m_ext_op = 3'b000;
        m_byteen = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
        @(posedge clk); #1;
        tests_run++;
        if ({dbg_state, dm_req, dm_we, m_bus_err, m_stall} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got state=%0d req=%b we=%b err=%b stall=%b, want all 0",
                     dbg_state, dm_req, dm_we, m_bus_err, m_stall);
        end
        tests_run++;
        if ({dm_addr, dm_be, dm_wdata, m_rdata} !== 100'h0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h be=%h wdata=%h rdata=%h, want 0",
                     dm_addr, dm_be, dm_wdata, m_rdata);
        end
        #1 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic check_load(input string name, input logic [2:0] ext, input logic [31:0] addr,
                              input int gd, input int rvd, input logic [31:0] rd,
                              input int exp_stall, input logic [31:0] exp_data);
        int sc; logic fin; logic [31:0] sa, sw; logic [3:0] sb; logic swe;
        begin_op(1'b1, 1'b0, ext, 4'h0, addr, 32'h0);
        do_access(gd, rvd, rd, sc, fin, sa, sb, sw, swe);
        tests_run++;
        if (!fin || sc != exp_stall || dbg_state !== S_DONE) begin
            fails++;
            $display("FAIL %s_stall: got done=%b stall=%0d state=%0d, want done=1 stall=%0d state=3",
                     name, fin, sc, dbg_state, exp_stall);
        end
        tests_run++;
        if (m_rdata !== exp_data || m_bus_err !== 1'b0) begin
            fails++;
            $display("FAIL %s_data: got rdata=%h err=%b, want rdata=%h err=0", name, m_rdata, m_bus_err, exp_data);
        end
        tests_run++;
        if (sa !== {addr[31:2], 2'b00} || sb !== 4'hF || swe !== 1'b0) begin
            fails++;
            $display("FAIL %s_bus: got addr=%h be=%h we=%b, want addr=%h be=f we=0",
                     name, sa, sb, swe, {addr[31:2], 2'b00});
        end
        end_op();
        tests_run++;
        if (dbg_state !== S_IDLE || m_rdata !== exp_data || m_stall !== 1'b0) begin
            fails++;
            $display("FAIL %s_after: got state=%0d rdata=%h stall=%b, want state=0 rdata=%h stall=0",
                     name, dbg_state, m_rdata, m_stall, exp_data);
        end
    endtask

    task automatic test_load_word();
        check_load("lw", 3'b000, 32'h104, 0, 1, 32'hDEADBEEF, 3, 32'hDEADBEEF);
        check_load("lw_rsv", 3'b111, 32'h100, 1, 2, 32'h12345678, 5, 32'h12345678);
    endtask

    task automatic test_load_byte_half();
        check_load("lb",  3'b010, 32'h103, 0, 1, 32'h80FFFF7F, 3, 32'hFFFFFF80);
        check_load("lbu", 3'b001, 32'h103, 0, 1, 32'h80FFFF7F, 3, 32'h00000080);
        check_load("lh",  3'b100, 32'h102, 0, 1, 32'h80FFFF7F, 3, 32'hFFFF80FF);
        check_load("lhu", 3'b011, 32'h100, 0, 1, 32'h80FFFF7F, 3, 32'h0000FF7F);
        check_load("lb0", 3'b010, 32'h100, 0, 1, 32'h80FFFF7F, 3, 32'h0000007F);
    endtask

    task automatic test_store_hold();
        logic [69:0] exp_bus;
        exp_bus = {1'b1, 1'b1, 4'b1100, 32'h00000200, 32'hABCDABCD};
        begin_op(1'b0, 1'b1, 3'b000, 4'b1100, 32'h202, 32'h1234ABCD);
        #1;
        tests_run++;
        if (m_stall !== 1'b1 || m_ades !== 1'b0) begin
            fails++;
            $display("FAIL sh_idle_stall: got stall=%b ades=%b, want stall=1 ades=0", m_stall, m_ades);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({dm_req, dm_we, dm_be, dm_addr, dm_wdata} !== exp_bus || m_stall !== 1'b1) begin
                fails++;
                $display("FAIL sh_hold%0d: got req=%b we=%b be=%b addr=%h wdata=%h stall=%b, want req=1 we=1 be=1100 addr=00000200 wdata=abcdabcd stall=1",
                         i, dm_req, dm_we, dm_be, dm_addr, dm_wdata, m_stall);
            end
            @(posedge clk); #1;
        end
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h0;
        @(posedge clk); #1;
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        tests_run++;
        if (dbg_state !== S_DONE || m_stall !== 1'b0 || dm_req !== 1'b0 || m_bus_err !== 1'b0) begin
            fails++;
            $display("FAIL sh_gnt_rvalid_done: got state=%0d stall=%b req=%b err=%b, want state=3 stall=0 req=0 err=0",
                     dbg_state, m_stall, dm_req, m_bus_err);
        end
        end_op();
    endtask

    task automatic test_store_byte_word();
        int sc; logic fin; logic [31:0] sa, sw; logic [3:0] sb; logic swe;
        begin_op(1'b0, 1'b1, 3'b000, 4'b0010, 32'h201, 32'h000000CD);
        do_access(0, 1, 32'h0, sc, fin, sa, sb, sw, swe);
        tests_run++;
        if (!fin || sc != 3 || sa !== 32'h200 || sb !== 4'b0010 || sw !== 32'hCDCDCDCD || swe !== 1'b1) begin
            fails++;
            $display("FAIL sb: got done=%b stall=%0d addr=%h be=%b wdata=%h we=%b, want 1 3 00000200 0010 cdcdcdcd 1",
                     fin, sc, sa, sb, sw, swe);
        end
        end_op();
        begin_op(1'b0, 1'b1, 3'b000, 4'b1111, 32'h300, 32'hCAFEF00D);
        do_access(2, 1, 32'h0, sc, fin, sa, sb, sw, swe);
        tests_run++;
        if (!fin || sc != 5 || sa !== 32'h300 || sb !== 4'b1111 || sw !== 32'hCAFEF00D || swe !== 1'b1) begin
            fails++;
            $display("FAIL sw: got done=%b stall=%0d addr=%h be=%b wdata=%h we=%b, want 1 5 00000300 1111 cafef00d 1",
                     fin, sc, sa, sb, sw, swe);
        end
        end_op();
    endtask

    task automatic test_back_to_back();
        check_load("b2b_a", 3'b000, 32'h400, 0, 0, 32'h11112222, 2, 32'h11112222);
        check_load("b2b_b", 3'b011, 32'h402, 0, 0, 32'h3333C444, 2, 32'h00003333);
    endtask

    task automatic test_misaligned();
        logic saw_req;
        begin_op(1'b1, 1'b0, 3'b000, 4'h0, 32'h106, 32'h0);
        #1;
        tests_run++;
        if (m_adel !== 1'b1 || m_ades !== 1'b0 || m_stall !== 1'b0) begin
            fails++;
            $display("FAIL lw_adel: got adel=%b ades=%b stall=%b, want 1 0 0", m_adel, m_ades, m_stall);
        end
        saw_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (dm_req !== 1'b0 || dbg_state !== S_IDLE) saw_req = 1'b1;
        end
        tests_run++;
        if (saw_req !== 1'b0) begin
            fails++;
            $display("FAIL lw_adel_nobus: got bus activity=%b, want 0", saw_req);
        end
        begin_op(1'b0, 1'b1, 3'b000, 4'b0011, 32'h101, 32'h5555AAAA);
        #1;
        tests_run++;
        if (m_ades !== 1'b1 || m_adel !== 1'b0 || m_stall !== 1'b0) begin
            fails++;
            $display("FAIL sh_ades: got ades=%b adel=%b stall=%b, want 1 0 0", m_ades, m_adel, m_stall);
        end
        saw_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (dm_req !== 1'b0 || dbg_state !== S_IDLE) saw_req = 1'b1;
        end
        tests_run++;
        if (saw_req !== 1'b0) begin
            fails++;
            $display("FAIL sh_ades_nobus: got bus activity=%b, want 0", saw_req);
        end
        begin_op(1'b1, 1'b0, 3'b100, 4'h0, 32'h101, 32'h0);
        #1;
        tests_run++;
        if (m_adel !== 1'b1 || m_stall !== 1'b0) begin
            fails++;
            $display("FAIL lh_adel: got adel=%b stall=%b, want 1 0", m_adel, m_stall);
        end
        end_op();
    endtask

    task automatic test_timeout();
        int n = 0;
        apply_reset();
        begin_op(1'b1, 1'b0, 3'b000, 4'h0, 32'h100, 32'h0);
        for (int c = 0; c < 50; c++) begin
            #1;
            if (!t4_m_stall) break;
            n++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (n != 5 || t4_dbg_state !== S_DONE) begin
            fails++;
            $display("FAIL timeout_cycles: got stall=%0d state=%0d, want stall=5 state=3", n, t4_dbg_state);
        end
        tests_run++;
        if (t4_m_bus_err !== 1'b1 || t4_m_rdata !== 32'h0 || t4_dm_req !== 1'b0) begin
            fails++;
            $display("FAIL timeout_err: got err=%b rdata=%h req=%b, want err=1 rdata=0 req=0",
                     t4_m_bus_err, t4_m_rdata, t4_dm_req);
        end
        end_op();
        tests_run++;
        if (t4_m_bus_err !== 1'b0 || t4_dbg_state !== S_IDLE) begin
            fails++;
            $display("FAIL timeout_err_clear: got err=%b state=%0d, want err=0 state=0", t4_m_bus_err, t4_dbg_state);
        end
    endtask

    task automatic test_reset_mid_resp();
        apply_reset();
        begin_op(1'b1, 1'b0, 3'b000, 4'h0, 32'h104, 32'h0);
        @(posedge clk); #1;
        dm_gnt = 1'b1;
        @(posedge clk); #1;
        dm_gnt = 1'b0;
        tests_run++;
        if (dbg_state !== S_RESP || m_stall !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre_resp: got state=%0d stall=%b, want state=2 stall=1", dbg_state, m_stall);
        end
        m_valid = 1'b0;
        reset = 1'b0;
        #1;
        tests_run++;
        if (dm_req !== 1'b0 || dbg_state !== S_IDLE || m_stall !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_resp: got req=%b state=%0d stall=%b, want 0 0 0", dm_req, dbg_state, m_stall);
        end
        reset = 1'b1;
        dm_rvalid = 1'b1; dm_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        dm_rvalid = 1'b0;
        tests_run++;
        if (dbg_state !== S_IDLE || m_rdata !== 32'h0) begin
            fails++;
            $display("FAIL rst_no_replay: got state=%0d rdata=%h, want state=0 rdata=0", dbg_state, m_rdata);
        end
        end_op();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_load_word();
        test_load_byte_half();
        test_store_hold();
        test_store_byte_word();
        test_back_to_back();
        test_misaligned();
        test_timeout();
        test_reset_mid_resp();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
